// File: rtl/stbc_frame_buffer.sv
// stbc_frame_buffer: double-buffered H/Y frame capture and per-candidate calc sequencer
// Build option: define STBC_PINGPONG_EN for two banks (loading overlaps calculation);
// left undefined, a single bank is used and loading/calculation serialise.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   H_in_valid/ready, H_in_r/i      H sample stream, row-major
//   Y_in_valid/ready, Y_in_r/i      Y sample stream, stored conjugated
//   sweep_en, q_sel                 run all NQ candidates, or only q_sel
//   calc_start, q_index, calc_done  per-candidate handshake with the datapath
//   rd_row, rd_col, rd_h_r/i        combinational H read from the read bank
//   rd_y_idx, rd_y_r/i              combinational conjugated Y read from the read bank
//   frame_done, busy, err_spurious  frame status
module stbc_frame_buffer #(
  parameter int N  = 32,
  parameter int Q  = 16,
  parameter int NR = 4,
  parameter int NC = 4,
  parameter int NY = 8,
  parameter int NQ = 16,
  parameter int QW = $clog2(NQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    H_in_valid,
  output logic                    H_in_ready,
  input  logic signed [N-1:0]     H_in_r,
  input  logic signed [N-1:0]     H_in_i,
  input  logic                    Y_in_valid,
  output logic                    Y_in_ready,
  input  logic signed [N-1:0]     Y_in_r,
  input  logic signed [N-1:0]     Y_in_i,
  input  logic                    sweep_en,
  input  logic [QW-1:0]           q_sel,
  output logic                    calc_start,
  output logic [QW-1:0]           q_index,
  input  logic                    calc_done,
  input  logic [$clog2(NR)-1:0]   rd_row,
  input  logic [$clog2(NC)-1:0]   rd_col,
  output logic signed [N-1:0]     rd_h_r,
  output logic signed [N-1:0]     rd_h_i,
  input  logic [$clog2(NY)-1:0]   rd_y_idx,
  output logic signed [N-1:0]     rd_y_r,
  output logic signed [N-1:0]     rd_y_i,
  output logic                    frame_done,
  output logic                    busy,
  output logic                    err_spurious
);
`ifdef STBC_PINGPONG_EN
  localparam logic PP = 1'b1;
`else
  localparam logic PP = 1'b0;
`endif
  localparam int NB  = PP ? 2 : 1;
  localparam int HT  = NR * NC;
  localparam int HAW = $clog2(HT);
  localparam int HCW = $clog2(HT + 1);
  localparam int YCW = $clog2(NY + 1);
  localparam logic [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};

  if (Q >= N) begin : g_bad_q
    $error("stbc_frame_buffer: Q must be smaller than N");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  logic [N-1:0]   r_h_r [NB][HT];
  logic [N-1:0]   r_h_i [NB][HT];
  logic [N-1:0]   r_y_r [NB][NY];
  logic [N-1:0]   r_y_i [NB][NY];
  logic [NB-1:0]  r_full;
  logic           r_wb, r_rb;
  logic [HCW-1:0] r_hcnt;
  logic [YCW-1:0] r_ycnt;
  state_t         r_state;
  logic [QW-1:0]  r_q;
  logic           r_sweep, r_start, r_fdone, r_busy, r_err;
  logic           w_h_fire, w_y_fire, w_h_end, w_y_end, w_free;
  logic [N-1:0]   w_yi_c;
  logic [HAW-1:0] w_h_addr;

  assign H_in_ready = !r_full[r_wb] && (r_hcnt < HCW'(HT));
  assign Y_in_ready = !r_full[r_wb] && (r_ycnt < YCW'(NY));
  assign w_h_fire   = H_in_valid && H_in_ready;
  assign w_y_fire   = Y_in_valid && Y_in_ready;
  // A stream counts as complete once its last word lands on this edge, so the bank
  // is published on the same edge as the final transfer.
  assign w_h_end    = (r_hcnt == HCW'(HT)) || (w_h_fire && r_hcnt == HCW'(HT - 1));
  assign w_y_end    = (r_ycnt == YCW'(NY)) || (w_y_fire && r_ycnt == YCW'(NY - 1));
  assign w_free     = (r_state == S_DONE);
  // Negating the most negative value would wrap, so it saturates to the max positive.
  assign w_yi_c     = (Y_in_i == MINV) ? ~MINV : -Y_in_i;
  assign w_h_addr   = HAW'(rd_row) * HAW'(NC) + HAW'(rd_col);

  assign rd_h_r       = r_h_r[r_rb][w_h_addr];
  assign rd_h_i       = r_h_i[r_rb][w_h_addr];
  assign rd_y_r       = r_y_r[r_rb][rd_y_idx];
  assign rd_y_i       = r_y_i[r_rb][rd_y_idx];
  assign calc_start   = r_start;
  assign q_index      = r_q;
  assign frame_done   = r_fdone;
  assign busy         = r_busy;
  assign err_spurious = r_err;

  always_ff @(posedge clk) begin
    if (w_h_fire) begin
      r_h_r[r_wb][r_hcnt[HAW-1:0]] <= H_in_r;
      r_h_i[r_wb][r_hcnt[HAW-1:0]] <= H_in_i;
    end
    if (w_y_fire) begin
      r_y_r[r_wb][r_ycnt[YCW-2:0]] <= Y_in_r;
      r_y_i[r_wb][r_ycnt[YCW-2:0]] <= w_yi_c;
    end
  end

  // A bank freed by DONE only reopens for writes on the following cycle, because
  // ready is derived from the registered full flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= '0;
      r_wb   <= 1'b0;
      r_hcnt <= '0;
      r_ycnt <= '0;
    end else begin
      if (w_free) r_full[r_rb] <= 1'b0;
      if (w_h_end && w_y_end) begin
        r_full[r_wb] <= 1'b1;
        r_wb         <= r_wb ^ PP;
        r_hcnt       <= '0;
        r_ycnt       <= '0;
      end else begin
        r_hcnt <= r_hcnt + HCW'(w_h_fire);
        r_ycnt <= r_ycnt + YCW'(w_y_fire);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rb    <= 1'b0;
      r_q     <= '0;
      r_sweep <= 1'b0;
      r_start <= 1'b0;
      r_fdone <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_fdone <= 1'b0;
      if (calc_done && r_state != S_WAIT) r_err <= 1'b1;
      case (r_state)
        S_IDLE: if (r_full[r_rb]) begin
          r_state <= S_START;
          r_start <= 1'b1;
          r_busy  <= 1'b1;
          r_sweep <= sweep_en;
          r_q     <= sweep_en ? '0 : q_sel;
        end
        S_START: r_state <= S_WAIT;
        S_WAIT: if (calc_done) begin
          if (r_sweep && r_q != QW'(NQ - 1)) begin
            r_q     <= r_q + QW'(1);
            r_state <= S_START;
            r_start <= 1'b1;
          end else begin
            r_state <= S_DONE;
            r_fdone <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_rb    <= r_rb ^ PP;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
